pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It generalises the fixed MEM/WB-style latch: payload width is a parameter, and the stage can stall and flush, which the plain latch cannot. It is instantiated between any two stages of the pipelined CPU, for example EX/MEM or MEM/WB. It optionally carries the instruction-trace sidecar (PC, jump flag) alongside the payload.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- PC_W, 32, trace PC width in bits (used only with trace enabled)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream holds a valid instruction (the have_inst equivalent)
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  payload: write data, register index, control bits, packed by the instantiator
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  stage presents a valid instruction
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  payload to the next stage
- in_pc / out_pc  in / out  PC_W  trace PC (PIPE_TRACE_EN only)
- in_j_type / out_j_type  in / out  1  trace jump flag (PIPE_TRACE_EN only)

## Operation
- Two entries: main (M) drives the outputs; skid (S) absorbs one beat while downstream stalls.
- Each entry holds {valid, data, [pc, j_type]}.
- Accept happens when in_valid && in_ready.
- Drain happens when out_valid && out_ready.
- in_ready = !S.valid. It is a direct register-bit decode with no combinational path from out_ready.
- Per-cycle update when flush=0:
  - M empty, or M draining with S empty: an accepted beat loads M.
  - M draining with S full: S moves to M. S then takes the accepted beat, if any; otherwise S empties.
  - M full and not draining: an accepted beat loads S. This is legal only while S is empty, which in_ready guarantees.
- Beats leave in arrival order. No beat is duplicated or lost.
- flush=1: M.valid and S.valid clear on the next edge.
  - flush beats a simultaneous accept; the incoming beat is dropped.
  - flush beats a simultaneous drain; the downstream still sees that drain cycle's beat as transferred.
  - Data registers keep their contents; only the valid bits clear.
- Data registers load only when their entry loads. No enable toggling occurs on idle cycles.

## Timing
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, S and M cleared, in_ready=1; with trace enabled, out_pc=0 and out_j_type=0.
- Release is synchronous to clk. The first accept is possible on the first edge with reset=1.
- Latency: accept at edge N gives out_valid=1 after edge N.
- Throughput is one beat per cycle while out_ready=1.
- Stall: first stalled accept fills M, second fills S. in_ready falls after the edge that fills S.
- Restart: first out_ready=1 cycle drains M. S moves to M on that edge and in_ready rises after it.
- Reset asserted mid-stall: both entries are discarded immediately, with no handshake needed.
- out_valid, out_data and in_ready are pure register outputs with no combinational input-to-output paths.

## Configuration
- PIPE_TRACE_EN defined: the in_pc/out_pc and in_j_type/out_j_type ports exist and travel in lock-step with the payload in both entries, under identical load, flush and reset rules.
- PIPE_TRACE_EN undefined: those ports and registers are absent. The payload behaviour and timing are unchanged.

## Test plan
- Reset: hold reset=0 with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, in_ready=1; release -> next edge out_data=32'hDEAD_BEEF, out_valid=1.
- Streaming: out_ready=1, feed 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following cycles, in_ready stays 1.
- Stall/skid:
  - Hold out_ready=0 and feed 0xA then 0xB -> in_ready=0 after the second edge, out_data=0xA held.
  - Raise out_ready -> out_data 0xA, then 0xB; in_ready=1 after the 0xA drain.
- Flush with accept: M=0xA and S=0xB full; assert flush together with in_valid=1, in_data=0xC -> next edge out_valid=0, in_ready=1, and 0xC never appears.
- Trace (PIPE_TRACE_EN): feed in_pc=32'h0000_0040 with in_j_type=1 under a two-cycle stall -> out_pc=32'h40 and out_j_type=1 stay aligned with their payload at every output cycle.
- Async reset mid-stall: S and M full, pulse reset=0 between edges -> out_valid drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream accept side, downstream drain side, flush.
// Trace sidecar signals exist only when PIPE_TRACE_EN is defined.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_TRACE_EN
  logic [PC_W-1:0]   in_pc;
  logic [PC_W-1:0]   out_pc;
  logic              in_j_type;
  logic              out_j_type;
`endif

  // master: the environment around the stage (upstream producer + downstream consumer)
  modport master (
    output in_valid, in_data, flush, out_ready,
`ifdef PIPE_TRACE_EN
    output in_pc, in_j_type,
    input  out_pc, out_j_type,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
`ifdef PIPE_TRACE_EN
    input  in_pc, in_j_type,
    output out_pc, out_j_type,
`endif
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer and synchronous flush.
// Define PIPE_TRACE_EN to carry the PC / jump-flag trace sidecar alongside the payload.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_skid_if.slave bus
);

  // Trace fields are packed above the payload so both entries move as one word.
`ifdef PIPE_TRACE_EN
  localparam int unsigned ENT_W = DATA_W + PC_W + 1;
`else
  localparam int unsigned ENT_W = DATA_W;
`endif

  logic [ENT_W-1:0] in_ent;
  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [ENT_W-1:0] m_ent_q, m_ent_d;
  logic [ENT_W-1:0] s_ent_q, s_ent_d;
  logic             m_load, s_load;
  logic             accept, drain;

`ifdef PIPE_TRACE_EN
  assign in_ent = {bus.in_j_type, bus.in_pc, bus.in_data};
`else
  assign in_ent = bus.in_data;
`endif

  assign accept = bus.in_valid && !s_valid_q;
  assign drain  = m_valid_q && bus.out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_ent_d   = m_ent_q;
    s_ent_d   = s_ent_q;
    m_load    = 1'b0;
    s_load    = 1'b0;
    if (bus.flush) begin
      // Only the valid bits clear; payload registers keep their contents.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || (drain && !s_valid_q)) begin
      m_valid_d = accept;
      if (accept) begin
        m_load  = 1'b1;
        m_ent_d = in_ent;
      end
    end else if (drain) begin
      m_load    = 1'b1;
      m_ent_d   = s_ent_q;
      s_valid_d = accept;
      if (accept) begin
        s_load  = 1'b1;
        s_ent_d = in_ent;
      end
    end else if (accept) begin
      s_load    = 1'b1;
      s_ent_d   = in_ent;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ent_q   <= '0;
      s_ent_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      if (m_load) m_ent_q <= m_ent_d;
      if (s_load) s_ent_q <= s_ent_d;
    end
  end

  assign bus.in_ready  = !s_valid_q;
  assign bus.out_valid = m_valid_q;
  assign bus.out_data  = m_ent_q[DATA_W-1:0];
`ifdef PIPE_TRACE_EN
  assign bus.out_pc     = m_ent_q[DATA_W +: PC_W];
  assign bus.out_j_type = m_ent_q[ENT_W-1];
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: reset, streaming, stall/skid, flush, async reset, trace.
module tb_pipe_stage_skid;
  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_errors;

  pipe_stage_skid_if #(.DATA_W(32), .PC_W(32)) bus ();

  pipe_stage_skid #(.DATA_W(32), .PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
`ifdef PIPE_TRACE_EN
    bus.in_pc     = '0;
    bus.in_j_type = 1'b0;
`endif
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef PIPE_TRACE_EN
    check("rst_out_pc", 64'(bus.out_pc),     64'd0);
    check("rst_out_j",  64'(bus.out_j_type), 64'd0);
`endif
    reset = 1'b1;
    tick();
    check("rel_out_valid", 64'(bus.out_valid), 64'd1);
    check("rel_out_data",  64'(bus.out_data),  64'hDEAD_BEEF);

    // streaming
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 32'(i);
      tick();
      check("stream_data",  64'(bus.out_data),  64'(i));
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_ready", 64'(bus.in_ready),  64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_empty", 64'(bus.out_valid), 64'd0);

    // stall / skid
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA;
    tick();
    check("stall1_ready", 64'(bus.in_ready), 64'd1);
    check("stall1_data",  64'(bus.out_data), 64'hA);
    bus.in_data = 32'hB;
    tick();
    check("stall2_ready", 64'(bus.in_ready), 64'd0);
    check("stall2_data",  64'(bus.out_data), 64'hA);
    bus.in_data = 32'hF;
    tick();
    check("stall3_ready", 64'(bus.in_ready), 64'd0);
    check("stall3_data",  64'(bus.out_data), 64'hA);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("restart_data",  64'(bus.out_data),  64'hB);
    check("restart_ready", 64'(bus.in_ready),  64'd1);
    check("restart_valid", 64'(bus.out_valid), 64'd1);
    tick();
    check("restart_empty", 64'(bus.out_valid), 64'd0);

    // flush with both entries full and a simultaneous beat offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA;
    tick();
    bus.in_data = 32'hB;
    tick();
    check("fl_full_ready", 64'(bus.in_ready), 64'd0);
    bus.flush   = 1'b1;
    bus.in_data = 32'hC;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", 64'(bus.out_valid), 64'd0);
    check("fl_in_ready",  64'(bus.in_ready),  64'd1);
    check("fl_data_kept", 64'(bus.out_data),  64'hA);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_c", 64'(bus.out_valid), 64'd0);
    end

    // flush beats an accept that in_ready would otherwise allow
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h11;
    tick();
    bus.flush   = 1'b1;
    bus.in_data = 32'h22;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_acc_valid", 64'(bus.out_valid), 64'd0);
    check("fl_acc_data",  64'(bus.out_data),  64'h11);

    // flush beats a drain
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h33;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_drain_valid", 64'(bus.out_valid), 64'd0);

    // async reset mid-stall
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h44;
    tick();
    bus.in_data = 32'h55;
    tick();
    bus.in_valid = 1'b0;
    check("ar_pre_ready", 64'(bus.in_ready), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("ar_out_valid", 64'(bus.out_valid), 64'd0);
    check("ar_out_data",  64'(bus.out_data),  64'd0);
    check("ar_in_ready",  64'(bus.in_ready),  64'd1);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("ar_after_valid", 64'(bus.out_valid), 64'd0);

`ifdef PIPE_TRACE_EN
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h55;
    bus.in_pc     = 32'h0000_0040;
    bus.in_j_type = 1'b1;
    tick();
    bus.in_data   = 32'h66;
    bus.in_pc     = 32'h0000_0044;
    bus.in_j_type = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("tr_stall_data", 64'(bus.out_data),   64'h55);
      check("tr_stall_pc",   64'(bus.out_pc),     64'h40);
      check("tr_stall_j",    64'(bus.out_j_type), 64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("tr_drain_data", 64'(bus.out_data),   64'h66);
    check("tr_drain_pc",   64'(bus.out_pc),     64'h44);
    check("tr_drain_j",    64'(bus.out_j_type), 64'd0);
    tick();
    check("tr_empty", 64'(bus.out_valid), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
